// File: rtl/magic_ctrl_pkg.sv
// Shared types and constants for the magic-ROM controller.
package magic_ctrl_pkg;

    typedef enum logic [1:0] {
        CHECK = 2'd0,
        RUN   = 2'd1,
        UNMAP = 2'd2
    } magic_state_t;

    localparam logic [7:0] CFG_IDX_CAUSE = 8'hFE;
    localparam logic [7:0] CFG_IDX_TRIG  = 8'hFF;

endpackage

// File: rtl/magic_ctrl_cfg_regs.sv
// Magic config register file: generic registers, W1C trigger cause and registered readback.
module magic_cfg_regs
    import magic_ctrl_pkg::*;
#(
    parameter int unsigned               NTRIG     = 2,
    parameter int unsigned               NREGS     = 16,
    parameter logic [NREGS*8-1:0]        CFG_RESET = '0
) (
    input  logic                  clk28,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [7:0]            idx,
    input  logic [7:0]            wdata,
    input  logic [NTRIG-1:0]      trig,
    input  logic [NTRIG-1:0]      trig_set,
    input  logic                  cause_clr,
    output logic [NREGS*8-1:0]    cfg,
    output logic [NTRIG-1:0]      cause,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    logic             rd_hit;
    logic [7:0]       rd_data;
    logic [NTRIG-1:0] w1c_mask;
    logic [NTRIG-1:0] cause_next;

    // Trigger bits are OR-ed in last so they survive both W1C and the exit clear.
    always_comb begin
        w1c_mask   = (cs && wr && idx == CFG_IDX_CAUSE) ? wdata[NTRIG-1:0] : '0;
        cause_next = ((cause_clr ? '0 : cause) & ~w1c_mask) | trig_set;
    end

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 8'(i)) begin
                rd_hit  = 1'b1;
                rd_data = cfg[i*8 +: 8];
            end
        end
        if (idx == CFG_IDX_CAUSE) begin
            rd_hit  = 1'b1;
            rd_data = 8'(cause);
        end
        if (idx == CFG_IDX_TRIG) begin
            rd_hit  = 1'b1;
            rd_data = 8'(trig);
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            cfg          <= CFG_RESET;
            cause        <= '0;
            d_out        <= 8'h00;
            d_out_active <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (cs && wr && idx == 8'(i)) begin
                    cfg[i*8 +: 8] <= wdata;
                end
            end
            cause        <= cause_next;
            d_out_active <= cs && rd && rd_hit;
            d_out        <= (cs && rd && rd_hit) ? rd_data : 8'h00;
        end
    end

endmodule

// File: rtl/magic_ctrl.sv
// Magic-ROM controller: NMI generation, ROM map/unmap sequencing and config port decode.
module magic_ctrl
    import magic_ctrl_pkg::*;
#(
    parameter int unsigned        NTRIG        = 2,
    parameter int unsigned        NREGS        = 16,
    parameter logic [NREGS*8-1:0] CFG_RESET    = '0,
    parameter logic [15:0]        VECTOR       = 16'h0066,
    parameter logic [15:0]        EXIT_ADDR    = 16'hF000,
    parameter logic [15:0]        REENTER_ADDR = 16'hF008,
    parameter logic [7:0]         SIGNATURE    = 8'hEB,
    parameter logic [7:0]         CFG_PORT     = 8'hFF
) (
    input  logic                  clk28,
    input  logic                  rst,
    input  logic [15:0]           bus_a,
    input  logic [7:0]            bus_d,
    input  logic                  bus_mreq,
    input  logic                  bus_ioreq,
    input  logic                  bus_rd,
    input  logic                  bus_wr,
    input  logic                  bus_m1,
    input  logic                  n_int,
    input  logic                  n_int_next,
    input  logic [NTRIG-1:0]      trig,
    output logic                  n_nmi,
    output logic                  magic_mode,
    output logic                  magic_map,
    output logic [NREGS*8-1:0]    cfg,
    output logic [NTRIG-1:0]      cause,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    magic_state_t     state;
    logic             reading;
    logic             match;
    logic             remap_pending;

    logic             fire;
    logic             fetch;
    logic             exit_hit;
    logic             reenter_hit;
    logic             map_hit;
    logic             cs;
    logic [NTRIG-1:0] trig_set;

    always_comb begin
        fire        = n_int && !n_int_next && (|trig);
        fetch       = bus_mreq && bus_m1 && bus_rd;
        exit_hit    = (state == RUN) && magic_map && bus_mreq && bus_rd &&
                      (bus_a == EXIT_ADDR) && !remap_pending;
        reenter_hit = (state == RUN) && magic_map && bus_mreq && bus_rd &&
                      (bus_a == REENTER_ADDR);
        map_hit     = (state == RUN) && !magic_map && magic_mode && bus_m1 && bus_mreq &&
                      ((bus_a == VECTOR) || remap_pending);
        cs          = magic_map && bus_ioreq && (bus_a[7:0] == CFG_PORT);
        trig_set    = fire ? trig : '0;
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state         <= CHECK;
            reading       <= 1'b0;
            match         <= 1'b0;
            remap_pending <= 1'b0;
            n_nmi         <= 1'b1;
            magic_mode    <= 1'b1;
            magic_map     <= 1'b1;
        end else begin
            case (state)
                CHECK: begin
                    if (!reading) begin
                        if (fetch) begin
                            match   <= (bus_d == SIGNATURE);
                            reading <= 1'b1;
                        end
                    end else if (!fetch) begin
                        reading    <= 1'b0;
                        magic_mode <= magic_mode && match;
                        magic_map  <= magic_map && match;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (exit_hit) begin
                        magic_mode <= 1'b0;
                        state      <= UNMAP;
                    end else if (reenter_hit) begin
                        remap_pending <= 1'b1;
                        state         <= UNMAP;
                    end else if (map_hit) begin
                        magic_map     <= 1'b1;
                        n_nmi         <= 1'b1;
                        remap_pending <= 1'b0;
                        if (bus_a == VECTOR) begin
                            reading <= 1'b0;
                            state   <= CHECK;
                        end
                    end
                end
                UNMAP: begin
                    if (!bus_mreq) begin
                        magic_map <= 1'b0;
                        state     <= RUN;
                    end
                end
                default: state <= CHECK;
            endcase

            // A trigger overrides everything, including an exit in the same clock.
            if (fire) begin
                magic_mode <= 1'b1;
                if (!magic_mode || exit_hit) begin
                    n_nmi <= 1'b0;
                end
            end
        end
    end

    magic_cfg_regs #(
        .NTRIG     (NTRIG),
        .NREGS     (NREGS),
        .CFG_RESET (CFG_RESET)
    ) u_cfg_regs (
        .clk28        (clk28),
        .rst          (rst),
        .cs           (cs),
        .wr           (bus_wr),
        .rd           (bus_rd),
        .idx          (bus_a[15:8]),
        .wdata        (bus_d),
        .trig         (trig),
        .trig_set     (trig_set),
        .cause_clr    (exit_hit),
        .cfg          (cfg),
        .cause        (cause),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

endmodule

// File: doc/magic_ctrl.md
Name: magic_ctrl

Overview:
Parametrised magic-ROM controller that generates the NMI, maps and unmaps the magic ROM, and hosts the magic configuration register file.
- Generalises the single-button scheme to NTRIG trigger sources, with a latched trigger cause.
- Configurable entry vector, exit addresses and opcode signature.
- NREGS generic 8-bit config registers with full readback.
- Sits between the CPU bus decode and the memory mapper; its outputs feed the ROM/RAM mapper and the chipset config.

Parameters:
NTRIG, 2, number of trigger inputs (1..8)
NREGS, 16, number of config registers (1..254)
CFG_RESET, all zeros, NREGS*8-bit reset image; register i occupies bits [8i+7:8i]
VECTOR, 16'h0066, NMI entry address that maps the ROM and starts the signature check
EXIT_ADDR, 16'hF000, mapped read here leaves magic mode
REENTER_ADDR, 16'hF008, mapped read here unmaps the ROM and remaps it at the next M1
SIGNATURE, 8'hEB, required first opcode of the magic ROM
CFG_PORT, 8'hFF, low I/O address byte of the config port

Ports:
clk28  in  1  system clock
rst  in  1  synchronous active-high reset
bus_a  in  16  CPU address
bus_d  in  8  CPU data in
bus_mreq, bus_ioreq, bus_rd, bus_wr, bus_m1  in  1 each  decoded active-high CPU strobes
n_int, n_int_next  in  1 each  current and next-cycle frame INT; a trigger fires when n_int=1 and n_int_next=0
trig  in  NTRIG  level trigger requests (buttons, external sources)
n_nmi  out  1  NMI to CPU, active low
magic_mode  out  1  magic session active
magic_map  out  1  magic ROM mapped
cfg  out  NREGS*8  config register contents
cause  out  NTRIG  latched trigger cause
d_out  out  8  read data
d_out_active  out  1  d_out drives the bus

Behaviour:
Reset (rst=1 at a clk28 edge):
- n_nmi=1, magic_mode=1, magic_map=1.
- state=CHECK, remap_pending=0, cause=0.
- cfg=CFG_RESET, d_out_active=0.

Trigger (evaluated every clock, in any state):
- Fires on an INT edge with |trig=1.
- cause |= trig.
- If magic_mode=0: n_nmi<=0.
- magic_mode<=1.

States:
- CHECK: on the first clock with mreq&m1&rd, latch match=(bus_d==SIGNATURE) and set reading=1. On the first clock after that with reading=1 and the strobe gone: magic_mode&=match, magic_map&=match, go to RUN.
- RUN, mapped (magic_map=1):
  - mreq&rd&a==EXIT_ADDR with remap_pending=0: magic_mode<=0, cause<=0, go to UNMAP.
  - mreq&rd&a==REENTER_ADDR: remap_pending<=1, go to UNMAP.
- UNMAP: on the first clock with mreq=0, magic_map<=0 and go to RUN.
- RUN, unmapped, magic_mode=1, m1&mreq, and (a==VECTOR or remap_pending=1):
  - magic_map<=1, n_nmi<=1, remap_pending<=0.
  - If a==VECTOR: go to CHECK. Otherwise stay in RUN.
- Transition priority: CHECK > EXIT > REENTER > UNMAP > map.

Collision rule: if a trigger fires in the same clock as an EXIT transition, the trigger wins. The result is magic_mode=1, n_nmi<=0, and cause keeps the new bits. UNMAP still proceeds.

Config port, cs = magic_map & ioreq & bus_a[7:0]==CFG_PORT; idx = bus_a[15:8]:
- Write, idx<NREGS: reg[idx]<=bus_d.
- Write, idx==8'hFE: cause &= ~bus_d[NTRIG-1:0] (write-1-to-clear).
- Any other write index is ignored.
- A trigger setting a bit in the same clock as a W1C clearing it leaves the bit set.

Readback (registered, one clock latency):
- d_out_active<=cs&rd&(idx<NREGS | idx==8'hFE | idx==8'hFF).
- d_out<= reg[idx], or cause zero-padded to 8 bits (idx 8'hFE), or trig zero-padded to 8 bits (idx 8'hFF).
- Both deassert one clock after cs&rd drops.
- No access while unmapped changes any state.

Reset mid-operation: the next clock is the reset state. A pending NMI is dropped and n_nmi returns high.

Decomposition:
Shared package (common):
- magic_state_t enum: CHECK, RUN, UNMAP.
- Constants CFG_IDX_CAUSE=8'hFE and CFG_IDX_TRIG=8'hFF.

Sub-module magic_cfg_regs:
- Register file, W1C cause logic and registered readback mux.
- Parametrised by NREGS, NTRIG, CFG_RESET.

The FSM, trigger logic and NMI logic stay in magic_ctrl.

Test Plan:
- Boot signature check: reset, first M1 fetch returns 8'hEB, then 8'h00 on a second run -> EB keeps magic_mode=magic_map=1; 00 drops both to 0 one clock after the fetch ends.
- NMI and exit: trig=2'b01 with an INT edge while magic_mode=0 -> n_nmi=0 and cause=01. M1 at 0x0066 -> n_nmi=1, map=1, CHECK passes. Read 0xF000 -> magic_mode=0 and cause=0 immediately; magic_map=0 on the first clock with mreq=0.
- Reenter: read 0xF008 while mapped -> map=0 after mreq drops; map=1 again on the next M1 at any address (e.g. 0x1234) without a signature check.
- Config registers: OUT (0x05FF),0xA5 then IN (0x05FF) -> cfg[47:40]=A5 and d_out=A5 with d_out_active one clock after rd. OUT (0x20FF) with NREGS=16 changes nothing. Any IN while unmapped -> d_out_active=0.
- Cause W1C and collision: cause=11, write 0x01 to idx 0xFE -> cause=10. Trigger on trig[0] in the same clock as the W1C -> cause=11. Trigger in the EXIT clock -> magic_mode=1, n_nmi=0.
- Mid-operation reset: rst asserted while n_nmi=0 in UNMAP -> next clock n_nmi=1, map=1, mode=1, cfg=CFG_RESET, cause=0.
